// File: rtl/writeback_stage_pkg.sv
// Shared constants for the write-back stage: load types, write-back select
// codes, SYSTEM opcode / CSR funct3 encodings and CSR addresses.
package writeback_stage_pkg;

    localparam logic [2:0] LD_LW  = 3'd0;
    localparam logic [2:0] LD_LH  = 3'd1;
    localparam logic [2:0] LD_LHU = 3'd2;
    localparam logic [2:0] LD_LB  = 3'd3;
    localparam logic [2:0] LD_LBU = 3'd4;

    localparam logic [1:0] WB_MEM = 2'd0;
    localparam logic [1:0] WB_ALU = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_CSR = 2'd3;

    localparam logic [4:0] OPC_SYSTEM = 5'b11100;
    localparam logic [2:0] F3_CSRRW   = 3'b001;
    localparam logic [2:0] F3_CSRRWI  = 3'b101;

    localparam logic [11:0] CSR_TOHOST  = 12'h51E;
    localparam logic [11:0] CSR_CYCLE   = 12'hC00;
    localparam logic [11:0] CSR_TIME    = 12'hC01;
    localparam logic [11:0] CSR_INSTRET = 12'hC02;

endpackage

// File: rtl/writeback_stage_if.sv
// EX-to-WB bundle: EX-registered controls and datapath values, the DMEM read
// word, and everything the write-back stage hands back to the core.
// slave = write-back stage, master = the EX stage / environment driving it.
interface writeback_stage_if;

    logic        Valid_EX_reg;
    logic        RegWen_EX_reg;
    logic [2:0]  LdSel_EX_reg;
    logic [1:0]  WBSel_EX_reg;
    logic        CSRSel_EX_reg;
    logic [31:0] Inst_EX_reg;
    logic [31:0] ALU_EX_reg;
    logic [31:0] PC4_EX_reg;
    logic [31:0] RS1_EX_reg;
    logic [31:0] DMem_dout;

    logic [31:0] WB_data;
    logic        RegWen_WB;
    logic [4:0]  rd_WB;
    logic [31:0] WB_data_reg;
    logic        RegWen_WB_reg;
    logic [4:0]  rd_WB_reg;
    logic [31:0] tohost;

    modport slave (
        input  Valid_EX_reg, RegWen_EX_reg, LdSel_EX_reg, WBSel_EX_reg, CSRSel_EX_reg,
        input  Inst_EX_reg, ALU_EX_reg, PC4_EX_reg, RS1_EX_reg, DMem_dout,
        output WB_data, RegWen_WB, rd_WB, WB_data_reg, RegWen_WB_reg, rd_WB_reg, tohost
    );

    modport master (
        output Valid_EX_reg, RegWen_EX_reg, LdSel_EX_reg, WBSel_EX_reg, CSRSel_EX_reg,
        output Inst_EX_reg, ALU_EX_reg, PC4_EX_reg, RS1_EX_reg, DMem_dout,
        input  WB_data, RegWen_WB, rd_WB, WB_data_reg, RegWen_WB_reg, rd_WB_reg, tohost
    );

endinterface

// File: rtl/writeback_stage_load_extract.sv
// load_extract: picks the byte/halfword addressed by the low address bits out
// of the DMEM word and sign- or zero-extends it. Misaligned halfwords simply
// use off[1]; no trap is raised here. Unknown load types behave as LW.
module load_extract
    import writeback_stage_pkg::*;
(
    input  logic [31:0] dmem_dout,
    input  logic [1:0]  off,
    input  logic [2:0]  ld_sel,
    output logic [31:0] load_data
);

    logic [15:0] half;
    logic [7:0]  byte_sel;

    // lane selection then extension by load type
    always_comb begin
        half = off[1] ? dmem_dout[31:16] : dmem_dout[15:0];
        case (off)
            2'd0:    byte_sel = dmem_dout[7:0];
            2'd1:    byte_sel = dmem_dout[15:8];
            2'd2:    byte_sel = dmem_dout[23:16];
            default: byte_sel = dmem_dout[31:24];
        endcase
        case (ld_sel)
            LD_LH:   load_data = {{16{half[15]}}, half};
            LD_LHU:  load_data = {16'h0, half};
            LD_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU:  load_data = {24'h0, byte_sel};
            default: load_data = dmem_dout;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage. Extends load data, selects the
// regfile write-back value, owns the tohost CSR and registers a WB copy for
// forwarding. Optional macro PERF_CNT_EN adds cycle/instret counters readable
// at 0xC00/0xC01 (cycle) and 0xC02 (instret); without it those addresses read 0.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter logic [11:0] TOHOST_ADDR  = CSR_TOHOST,
    parameter logic [31:0] RESET_TOHOST = 32'h0
) (
    input  logic          clk,
    input  logic          rst,
    writeback_stage_if.slave wb
);

    logic [4:0]  rd;
    logic [11:0] csr_addr;
    logic [2:0]  funct3;
    logic [4:0]  zimm;
    logic [4:0]  opcode;
    logic        unused_inst_lo;
    logic        csr_wen;
    logic [31:0] csr_rdata;
    logic [31:0] load_data;
    logic [31:0] tohost_q;

    assign rd             = wb.Inst_EX_reg[11:7];
    assign csr_addr       = wb.Inst_EX_reg[31:20];
    assign funct3         = wb.Inst_EX_reg[14:12];
    assign zimm           = wb.Inst_EX_reg[19:15];
    assign opcode         = wb.Inst_EX_reg[6:2];
    assign unused_inst_lo = ^wb.Inst_EX_reg[1:0];

    // Only csrrw/csrrwi of a real instruction modify tohost.
    assign csr_wen = wb.Valid_EX_reg && (opcode == OPC_SYSTEM)
                     && ((funct3 == F3_CSRRW) || (funct3 == F3_CSRRWI))
                     && (csr_addr == TOHOST_ADDR);

    load_extract u_load_extract (
        .dmem_dout (wb.DMem_dout),
        .off       (wb.ALU_EX_reg[1:0]),
        .ld_sel    (wb.LdSel_EX_reg),
        .load_data (load_data)
    );

`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;

    // free-running performance counters, wrapping naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt   <= 32'h0;
            instret_cnt <= 32'h0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (wb.Valid_EX_reg)
                instret_cnt <= instret_cnt + 32'd1;
        end
    end
`endif

    // CSR read mux; reads see the value before this cycle's update
    always_comb begin
        csr_rdata = 32'h0;
        if (csr_addr == TOHOST_ADDR)
            csr_rdata = tohost_q;
`ifdef PERF_CNT_EN
        else if ((csr_addr == CSR_CYCLE) || (csr_addr == CSR_TIME))
            csr_rdata = cycle_cnt;
        else if (csr_addr == CSR_INSTRET)
            csr_rdata = instret_cnt;
`endif
    end

    // write-back value select
    always_comb begin
        case (wb.WBSel_EX_reg)
            WB_MEM:  wb.WB_data = load_data;
            WB_ALU:  wb.WB_data = wb.ALU_EX_reg;
            WB_PC4:  wb.WB_data = wb.PC4_EX_reg;
            default: wb.WB_data = csr_rdata;
        endcase
    end

    assign wb.RegWen_WB = wb.RegWen_EX_reg && wb.Valid_EX_reg && (rd != 5'd0);
    assign wb.rd_WB     = rd;
    assign wb.tohost    = tohost_q;

    // tohost CSR and the forwarding copy of this stage's result
    always_ff @(posedge clk) begin
        if (rst) begin
            tohost_q         <= RESET_TOHOST;
            wb.WB_data_reg   <= 32'h0;
            wb.RegWen_WB_reg <= 1'b0;
            wb.rd_WB_reg     <= 5'd0;
        end else begin
            if (csr_wen)
                tohost_q <= wb.CSRSel_EX_reg ? {27'b0, zimm} : wb.RS1_EX_reg;
            wb.WB_data_reg   <= wb.WB_data;
            wb.RegWen_WB_reg <= wb.RegWen_WB;
            wb.rd_WB_reg     <= wb.rd_WB;
        end
    end

endmodule
